// File: rtl/axi4_burst_writer.sv
// AXI4 write-burst master: accepts one command at a time, issues AW, then streams
// beats from an internal data FIFO on W. No write-response handling.
module axi4_burst_writer #(
  parameter int AXI_ID_WIDTH_P   = 3,
  parameter int AXI_ADDR_WIDTH_P = 32,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_STRB_WIDTH_P = 4,
  parameter int AXI_ID_P         = 0,
  parameter int FIFO_DEPTH_P     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [AXI_ADDR_WIDTH_P-1:0]     cmd_addr,
  input  logic [7:0]                      cmd_len,
  input  logic [AXI_DATA_WIDTH_P-1:0]     wr_data,
  input  logic [AXI_STRB_WIDTH_P-1:0]     wr_strb,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [$clog2(FIFO_DEPTH_P):0]   fifo_fill,
  output logic                            busy,
  output logic                            done,
  output logic [AXI_ID_WIDTH_P-1:0]       awid,
  output logic [AXI_ADDR_WIDTH_P-1:0]     awaddr,
  output logic [7:0]                      awlen,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [AXI_DATA_WIDTH_P-1:0]     wdata,
  output logic [AXI_STRB_WIDTH_P-1:0]     wstrb,
  output logic                            wlast,
  output logic                            wvalid,
  input  logic                            wready
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH_P);
  localparam int FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                      state;
  logic [AXI_ADDR_WIDTH_P-1:0] addr_q;
  logic [7:0]                  len_q;
  logic [7:0]                  beat_cnt;

  logic [AXI_DATA_WIDTH_P-1:0] data_mem [FIFO_DEPTH_P];
  logic [AXI_STRB_WIDTH_P-1:0] strb_mem [FIFO_DEPTH_P];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [FILL_W-1:0]           fill;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FILL_W'(FIFO_DEPTH_P));
  assign push       = wr_valid && wr_ready;
  assign pop        = wvalid && wready;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wr_ready   = !fifo_full;
  assign fifo_fill  = fill;

  assign awid       = AXI_ID_WIDTH_P'(AXI_ID_P);
  assign awaddr     = addr_q;
  assign awlen      = len_q;

  // W channel reads the FIFO head directly; a push only becomes visible once fill updates
  assign wvalid     = (state == DATA) && !fifo_empty;
  assign wlast      = wvalid && (beat_cnt == len_q);
  assign wdata      = data_mem[rd_ptr];
  assign wstrb      = strb_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      awvalid  <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            awvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (wlast) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO control; depth is a power of two so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= wr_data;
      strb_mem[wr_ptr] <= wr_strb;
    end
  end

endmodule

// File: doc/axi4_burst_writer.md
AXI4_BURST_WRITER -- requirements
Module: axi4_burst_writer

Interface
REQ-001 Parameter AXI_ID_WIDTH_P, default 3: width of awid.
REQ-002 Parameter AXI_ADDR_WIDTH_P, default 32: width of cmd_addr and awaddr.
REQ-003 Parameter AXI_DATA_WIDTH_P, default 32: width of wr_data and wdata.
REQ-004 Parameter AXI_STRB_WIDTH_P, default 4: width of wr_strb and wstrb.
REQ-005 Parameter AXI_ID_P, default 0: constant value driven on awid.
REQ-006 Parameter FIFO_DEPTH_P, default 16: data FIFO depth; it SHALL be a power of two and at least 2.
REQ-007 The clock SHALL be clk, input, 1 bit; the reset SHALL be rst_n, input, 1 bit, asynchronous, active-low.
REQ-008 Command ports: cmd_valid in 1; cmd_ready out 1; cmd_addr in AXI_ADDR_WIDTH_P, burst start address; cmd_len in 8, beats minus 1.
REQ-009 Data push ports: wr_data in AXI_DATA_WIDTH_P; wr_strb in AXI_STRB_WIDTH_P; wr_valid in 1; wr_ready out 1.
REQ-010 Status ports: fifo_fill out $clog2(FIFO_DEPTH_P)+1, stored beats; busy out 1, high when not IDLE; done out 1, one-cycle pulse per completed burst.
REQ-011 AXI4 master ports: awid out ID, awaddr out ADDR, awlen out 8, awvalid out 1, awready in 1; wdata out DATA, wstrb out STRB, wlast out 1, wvalid out 1, wready in 1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-013 cmd_ready SHALL equal 1 exactly when the state is IDLE, decoded combinationally from the state register.
REQ-014 In IDLE, a cmd_valid&&cmd_ready handshake SHALL latch cmd_addr and cmd_len, set awvalid on the next cycle, and move to ADDR.
REQ-015 awaddr and awlen SHALL come from the latched registers; awid SHALL equal AXI_ID_P constantly.
REQ-016 In ADDR, awvalid SHALL stay 1 and awaddr/awlen SHALL stay stable until awvalid&&awready.
REQ-017 On the awvalid&&awready cycle, awvalid SHALL clear on the next edge and the FSM SHALL move to DATA.
REQ-018 In DATA, wvalid SHALL equal (FIFO not empty); in IDLE and ADDR, wvalid SHALL be 0.
REQ-019 wdata and wstrb SHALL present the FIFO head entry combinationally.
REQ-020 An 8-bit beat counter, cleared in IDLE, SHALL increment on each wvalid&&wready cycle.
REQ-021 wlast SHALL equal wvalid && (beat counter == latched len).
REQ-022 Each wvalid&&wready cycle SHALL pop one FIFO entry.
REQ-023 On wvalid&&wready&&wlast, the FSM SHALL return to IDLE and done SHALL pulse 1 on the following cycle.
REQ-024 The block SHALL complete a transaction on wlast acceptance and SHALL NOT wait for a write response.
REQ-025 wr_ready SHALL equal (FIFO not full); each wr_valid&&wr_ready cycle SHALL push one entry in any state.
REQ-026 There SHALL be no same-cycle bypass: a beat pushed into an empty FIFO becomes visible on wvalid one cycle later.
REQ-027 A simultaneous push and pop SHALL leave fifo_fill unchanged; pointers SHALL wrap modulo FIFO_DEPTH_P.
REQ-028 fifo_fill SHALL reach FIFO_DEPTH_P when full, and a push while full SHALL be impossible because wr_ready is 0.
REQ-029 cmd_len of 0 SHALL produce a single-beat burst with wlast on its only beat.
REQ-030 Data stored beyond the current burst length SHALL remain in the FIFO for the next burst.

Reset
REQ-031 On rst_n low, regardless of clk, the block SHALL enter IDLE and clear awvalid, done, the beat counter, the FIFO pointers and fifo_fill, while AWADDR/AWLEN registers reset to 0.
REQ-032 During reset, busy, wvalid and wlast SHALL be 0, cmd_ready SHALL be 1 and wr_ready SHALL be 1.
REQ-033 Reset asserted mid-burst SHALL discard the outstanding burst and all FIFO contents with no further AW or W activity.

Verification
REQ-034 Test 1: push 4 beats, command addr 0x1000, len 3, awready 1 cycle after awvalid, wready held high -> awaddr 0x1000, awlen 3, 4 beats with wlast on the 4th, done pulses once, then IDLE.
REQ-035 Test 2: command len 7 with an empty FIFO, then push 1 beat every 3 cycles -> wvalid gaps track the FIFO, 8 beats total, wlast only on beat 8.
REQ-036 Test 3: hold awready 0 for 10 cycles -> awvalid, awaddr and awlen stay stable, wvalid stays 0, and no pop occurs.
REQ-037 Test 4: push 16 beats with wready 0 -> fifo_fill 16 and wr_ready 0; then toggle wready and drive simultaneous push/pop -> fill stable and data order preserved across pointer wrap.
REQ-038 Test 5: command len 0 -> single beat with wlast 1; back-to-back commands are accepted on the cycle after done or later.
REQ-039 Test 6: assert rst_n low during beat 2 of a len-5 burst -> all outputs take reset values immediately, fifo_fill 0, and a new burst after reset completes correctly.
